// File: rtl/cache_controller.sv
// MSI cache-line controller: sequences one processor request into datapath commands and bus traffic.
// Latency: read hit 2 cycles, write hit 3; misses stall on bus_grant and mem_ack, bounded by ACK_TIMEOUT.
module cache_controller #(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_valid,
    input  logic [1:0]       p_func,
    input  logic             read_hit,
    input  logic             write_hit,
    input  logic [1:0]       stat,
    input  logic             bus_grant,
    input  logic             snoop_hit_in,
    input  logic             mem_ack,
    output logic [1:0]       func,
    output logic             snoop_out,
    output logic             bus_req,
    output logic             p_ready,
    output logic             err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [2:0] {IDLE, LOOKUP, UPG, WB, SNOOP, MEM_RD, WRITE, DONE} state_t;

    localparam int              TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [1:0]      F_PRD    = 2'b00;
    localparam logic [1:0]      F_PWR    = 2'b01;
    localparam logic [1:0]      F_BRD    = 2'b10;
    localparam logic [1:0]      F_BWR    = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic             is_wr_q;
    logic             counted_q;
    logic [TW-1:0]    tmo_q;
    logic [1:0]       func_q;
    logic             snoop_q;
    logic             req_q;
    logic             rdy_q;
    logic             err_q;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] miss_q;

    logic [CNT_W-1:0] hit_d;
    logic [CNT_W-1:0] miss_d;
    logic [1:0]       bus_func_d;

    assign hit_d      = (hit_q  == CNT_MAX) ? hit_q  : hit_q  + CNT_W'(1);
    assign miss_d     = (miss_q == CNT_MAX) ? miss_q : miss_q + CNT_W'(1);
    assign bus_func_d = (state_q == WB) ? F_BWR : F_BRD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            counted_q <= 1'b0;
            tmo_q     <= '0;
            func_q    <= F_PRD;
            snoop_q   <= 1'b0;
            req_q     <= 1'b0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            hit_q     <= '0;
            miss_q    <= '0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    counted_q <= 1'b0;
                    if (p_valid && !p_func[1]) begin
                        is_wr_q <= p_func[0];
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Only the first lookup of a request is counted; retries after a refill are not.
                    counted_q <= 1'b1;
                    if (!is_wr_q && read_hit) begin
                        if (!counted_q) hit_q <= hit_d;
                        state_q <= DONE;
                        rdy_q   <= 1'b1;
                        req_q   <= 1'b0;
                    end else if (is_wr_q && write_hit) begin
                        if (!counted_q) hit_q <= hit_d;
                        state_q <= WRITE;
                        func_q  <= F_PWR;
                    end else if (is_wr_q && read_hit) begin
                        if (!counted_q) hit_q <= hit_d;
                        state_q <= UPG;
                        req_q   <= 1'b1;
                    end else begin
                        if (!counted_q) miss_q <= miss_d;
                        req_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= (stat == 2'b11) ? WB : SNOOP;
                    end
                end
                UPG: begin
                    if (bus_grant) begin
                        state_q <= WRITE;
                        func_q  <= F_PWR;
                    end
                end
                WB, MEM_RD: begin
                    // An ack is accepted only once the bus command is actually on func.
                    if (func_q == bus_func_d && mem_ack) begin
                        func_q <= F_PRD;
                        if (state_q == WB) begin
                            state_q <= SNOOP;
                            snoop_q <= bus_grant;
                        end else begin
                            state_q <= LOOKUP;
                        end
                    end else if (!bus_grant) begin
                        func_q <= F_PRD;
                    end else if (func_q != bus_func_d) begin
                        func_q <= bus_func_d;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        func_q  <= F_PRD;
                        state_q <= DONE;
                        rdy_q   <= 1'b1;
                        req_q   <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                SNOOP: begin
                    if (snoop_q) begin
                        snoop_q <= 1'b0;
                        if (snoop_hit_in) begin
                            if (is_wr_q) begin
                                state_q <= WRITE;
                                func_q  <= F_PWR;
                            end else begin
                                state_q <= LOOKUP;
                            end
                        end else begin
                            state_q <= MEM_RD;
                            tmo_q   <= '0;
                            func_q  <= bus_grant ? F_BRD : F_PRD;
                        end
                    end else if (bus_grant) begin
                        snoop_q <= 1'b1;
                    end
                end
                WRITE: begin
                    func_q  <= F_PRD;
                    state_q <= DONE;
                    rdy_q   <= 1'b1;
                    req_q   <= 1'b0;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign func      = func_q;
    assign snoop_out = snoop_q;
    assign bus_req   = req_q;
    assign p_ready   = rdy_q;
    assign err       = err_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

endmodule
